// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the instruction memory loader.
// The loader uses the slave modport; the byte source uses the master modport.
interface imem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Assembles a length-prefixed little-endian byte stream into 32-bit words written to instruction memory.
// Optional trailer checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    imem_loader_if.slave bus,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t FINISH = S_CSUM;
`else
    localparam state_t FINISH = S_DONE;
`endif

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] words_loaded_q, words_loaded_d;
    logic [15:0] len_q, len_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [23:0] asm_q, asm_d;
    logic [1:0]  idx_q, idx_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    logic        xfer;
    logic [15:0] len_in;

    assign xfer   = in_ready_q & bus.in_valid;
    assign len_in = {bus.in_data, len_lo_q};

    always_comb begin
        state_d        = state_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        words_loaded_d = words_loaded_q;
        len_d          = len_q;
        len_lo_d       = len_lo_q;
        asm_d          = asm_q;
        idx_d          = idx_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d          = sum_q;
        if (xfer && (state_q == S_LEN_LO || state_q == S_LEN_HI || state_q == S_DATA))
            sum_d = sum_q + bus.in_data;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d        = S_LEN_LO;
                    words_loaded_d = 16'd0;
                    mem_addr_d     = BASE_ADDR;
                    idx_d          = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d          = 8'd0;
`endif
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_lo_d = bus.in_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d = len_in;
                    if (len_in > MAX_W)
                        state_d = S_ERR;
                    else if (len_in == 16'd0)
                        state_d = FINISH;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    idx_d = idx_q + 2'd1;
                    // Bytes 0..2 shift in from the top so byte 0 ends up in the low lane.
                    if (idx_q == 2'd3) begin
                        mem_we_d       = 1'b1;
                        mem_wdata_d    = {bus.in_data, asm_q};
                        mem_addr_d     = BASE_ADDR + {14'd0, words_loaded_q, 2'b00};
                        words_loaded_d = words_loaded_q + 16'd1;
                        if (words_loaded_q + 16'd1 == len_q)
                            state_d = FINISH;
                    end else begin
                        asm_d = {bus.in_data, asm_q[23:8]};
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer)
                    state_d = (8'(sum_q + bus.in_data) == 8'd0) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                     (state_d == S_DATA)   || (state_d == S_CSUM);
        busy_d     = in_ready_d;
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= BASE_ADDR;
            mem_wdata_q    <= 32'd0;
            words_loaded_q <= 16'd0;
            len_q          <= 16'd0;
            len_lo_q       <= 8'd0;
            asm_q          <= 24'd0;
            idx_q          <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q          <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            words_loaded_q <= words_loaded_d;
            len_q          <= len_d;
            len_lo_q       <= len_lo_d;
            asm_q          <= asm_d;
            idx_q          <= idx_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q          <= sum_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign words_loaded  = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a frame-level model queues expected writes and status,
// a negedge monitor pops and compares every mem_we pulse.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 64;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] cnt;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [15:0] words_loaded;

    int vectors = 0;
    int miscompares = 0;

    wr_t        exp_q[$];
    logic [7:0] frame_q[$];

    imem_loader_if bus();

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .bus(bus),
        .busy(busy),
        .done(done),
        .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every write pulse must match the oldest outstanding expected write.
    always @(negedge clk) begin
        wr_t e;
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_write: got addr %h data %h, expected no write at %0t",
                         bus.mem_addr, bus.mem_wdata, $time);
            end else begin
                e = exp_q.pop_front();
                check_output("write_addr", bus.mem_addr, e.addr);
                check_output("write_data", bus.mem_wdata, e.data);
                check_output("write_count", {16'd0, words_loaded}, {16'd0, e.cnt});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        start = 1'b1;
        idle_cycle();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit accepted = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                accepted = 1;
                break;
            end
        end
        if (accepted) begin
            @(posedge clk);
            #1;
        end else begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL byte_accept: got in_ready low for 50 cycles, expected acceptance at %0t", $time);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic append_trailer(input bit good);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] s = 8'd0;
        foreach (frame_q[i]) s = s + frame_q[i];
        if (good) frame_q.push_back(8'(0 - s));
        else      frame_q.push_back(8'(0 - s + 1 + $urandom_range(0, 254)));
`else
        if (good) frame_q.delete(frame_q.size());
`endif
    endtask

    task automatic build_frame(input int n, input bit good);
        frame_q.delete();
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        if (n <= MAXW) begin
            for (int i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom));
            append_trailer(good);
        end
    endtask

    // Frame-level model: writes and final status come from the byte layout alone.
    task automatic apply_stimulus(input int gap_mode, input bit poke_start);
        int  n, nsend;
        bit  oversize, exp_err;
        n        = {frame_q[1], frame_q[0]};
        oversize = n > MAXW;
        if (!oversize) begin
            for (int i = 0; i < n; i++) begin
                wr_t w;
                w.addr = BASE + 32'(4 * i);
                w.data = {frame_q[2+4*i+3], frame_q[2+4*i+2], frame_q[2+4*i+1], frame_q[2+4*i]};
                w.cnt  = 16'(i + 1);
                exp_q.push_back(w);
            end
        end
        nsend   = oversize ? 2 : frame_q.size();
        exp_err = oversize;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!oversize) begin
            logic [7:0] s = 8'd0;
            foreach (frame_q[i]) s = s + frame_q[i];
            exp_err = (s != 8'd0);
        end
`endif
        start_load();
        check_output("start_busy", {31'd0, busy}, 32'd1);
        check_output("start_ready", {31'd0, bus.in_ready}, 32'd1);
        check_output("start_done_clr", {31'd0, done}, 32'd0);
        check_output("start_err_clr", {31'd0, err}, 32'd0);
        check_output("start_count_clr", {16'd0, words_loaded}, 32'd0);
        check_output("start_addr", bus.mem_addr, BASE);
        for (int k = 0; k < nsend; k++) begin
            if (poke_start && k == 1) start_load();
            if (gap_mode == 1 && k > 0) idle_cycle();
            if (gap_mode == 2) repeat ($urandom_range(0, 2)) idle_cycle();
            send_byte(frame_q[k]);
        end
        check_output("end_done", {31'd0, done}, {31'd0, !exp_err});
        check_output("end_err", {31'd0, err}, {31'd0, exp_err});
        check_output("end_ready", {31'd0, bus.in_ready}, 32'd0);
        check_output("end_busy", {31'd0, busy}, 32'd0);
        idle_cycle();
        idle_cycle();
        check_output("pending_writes", exp_q.size(), 32'd0);
        check_output("end_count", {16'd0, words_loaded}, oversize ? 32'd0 : 32'(n));
        check_output("sticky_done", {31'd0, done}, {31'd0, !exp_err});
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check_output({tag, "_we"}, {31'd0, bus.mem_we}, 32'd0);
        check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_output({tag, "_done"}, {31'd0, done}, 32'd0);
        check_output({tag, "_err"}, {31'd0, err}, 32'd0);
        check_output({tag, "_addr"}, bus.mem_addr, BASE);
        check_output({tag, "_wdata"}, bus.mem_wdata, 32'd0);
        check_output({tag, "_count"}, {16'd0, words_loaded}, 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        #1;
        check_reset_values("reset");
        #11;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_output("idle_ready", {31'd0, bus.in_ready}, 32'd0);
        idle_cycle();

        $display("[TB] single word frame");
        frame_q = '{8'h01, 8'h00, 8'h83, 8'h24, 8'h05, 8'h0F};
        append_trailer(1);
        apply_stimulus(0, 0);

        $display("[TB] three words with in_valid toggling");
        build_frame(3, 1);
        apply_stimulus(1, 0);

        $display("[TB] oversize length");
        build_frame(65, 1);
        apply_stimulus(0, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        $display("[TB] checksum trailers");
        frame_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEC};
        apply_stimulus(0, 0);
        frame_q = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hED};
        apply_stimulus(0, 0);
`endif

        $display("[TB] empty frame");
        build_frame(0, 1);
        apply_stimulus(0, 0);

        $display("[TB] random frames");
        for (int f = 0; f < 24; f++) begin
            int n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(65, 400)) : int'($urandom_range(0, 6));
            build_frame(n, $urandom_range(0, 3) != 0);
            apply_stimulus(2, (n > 0 && $urandom_range(0, 2) == 0));
        end

        $display("[TB] reset during second word");
        build_frame(2, 1);
        begin
            wr_t w;
            w.addr = BASE;
            w.data = {frame_q[5], frame_q[4], frame_q[3], frame_q[2]};
            w.cnt  = 16'd1;
            exp_q.push_back(w);
        end
        start_load();
        for (int k = 0; k < 9; k++) send_byte(frame_q[k]);
        reset = 1'b0;
        #1;
        check_reset_values("abort");
        check_output("abort_pending", exp_q.size(), 32'd0);
        repeat (3) idle_cycle();
        reset = 1'b1;
        repeat (3) idle_cycle();
        check_output("abort_idle_ready", {31'd0, bus.in_ready}, 32'd0);
        build_frame(1, 1);
        apply_stimulus(0, 0);

        repeat (3) idle_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
